// File: rtl/mem_io_bridge.sv
// CPU-to-memory/I/O bridge: edge-triggered requests, single mapped
// I/O word (switches/hex), fixed-wait memory reads.
module mem_io_bridge #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] CPU_WDATA,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  input  logic [9:0]  SW,
  input  logic [15:0] MEM_RDATA,
  output logic [15:0] CPU_RDATA,
  output logic        R,
  output logic        BUSY,
  output logic [9:0]  MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic        MEM_RDEN,
  output logic        MEM_WREN,
  output logic [15:0] HEX_DATA
);

  typedef enum logic [2:0] {
    IDLE,
    IO,
    MEM_RD,
    MEM_WR,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync;
  logic        rd_prev;
  logic        wr_prev;
  logic        op_wr;
  logic [3:0]  wait_cnt;
  logic        rd_rise;
  logic        wr_rise;

  assign rd_rise = CPU_RD & ~rd_prev;
  assign wr_rise = CPU_WR & ~wr_prev;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      sw_meta   <= '0;
      sw_sync   <= '0;
      // held strobes must be released before they count again
      rd_prev   <= 1'b1;
      wr_prev   <= 1'b1;
      op_wr     <= 1'b0;
      wait_cnt  <= '0;
      CPU_RDATA <= '0;
      HEX_DATA  <= '0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      R         <= 1'b0;
      BUSY      <= 1'b0;
      MEM_RDEN  <= 1'b0;
      MEM_WREN  <= 1'b0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      rd_prev <= CPU_RD;
      wr_prev <= CPU_WR;
      R       <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_rise || rd_rise) begin
            // simultaneous edges resolve to the write
            op_wr     <= wr_rise;
            MEM_ADDR  <= ADDR[9:0];
            MEM_WDATA <= CPU_WDATA;
            BUSY      <= 1'b1;
            if (ADDR == IO_ADDR) begin
              state <= IO;
            end else if (wr_rise) begin
              state    <= MEM_WR;
              MEM_WREN <= 1'b1;
            end else begin
              state    <= MEM_RD;
              MEM_RDEN <= 1'b1;
              wait_cnt <= '0;
            end
          end
        end
        IO: begin
          if (op_wr) begin
            HEX_DATA <= MEM_WDATA;
          end else begin
            CPU_RDATA <= {6'b0, sw_sync};
          end
          R     <= 1'b1;
          state <= DONE;
        end
        MEM_RD: begin
          if (wait_cnt == WAIT_LAST) begin
            CPU_RDATA <= MEM_RDATA;
            MEM_RDEN  <= 1'b0;
            R         <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        MEM_WR: begin
          MEM_WREN <= 1'b0;
          R        <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY     <= 1'b0;
          MEM_RDEN <= 1'b0;
          MEM_WREN <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed scenarios with literal expectations
// plus random traffic against a transaction-level model.
module tb_mem_io_bridge;

  localparam int W = 2;
  localparam logic [15:0] IOA = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] CPU_WDATA;
  logic        CPU_RD;
  logic        CPU_WR;
  logic [9:0]  SW;
  logic [15:0] MEM_RDATA;
  logic [15:0] CPU_RDATA;
  logic        R;
  logic        BUSY;
  logic [9:0]  MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic        MEM_RDEN;
  logic        MEM_WREN;
  logic [15:0] HEX_DATA;

  mem_io_bridge #(.WAIT_CYCLES(W), .IO_ADDR(IOA)) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR),
    .CPU_WDATA(CPU_WDATA), .CPU_RD(CPU_RD),
    .CPU_WR(CPU_WR), .SW(SW), .MEM_RDATA(MEM_RDATA),
    .CPU_RDATA(CPU_RDATA), .R(R), .BUSY(BUSY),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDEN(MEM_RDEN), .MEM_WREN(MEM_WREN),
    .HEX_DATA(HEX_DATA)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int r_cnt = 0;
  int rden_cnt = 0;
  int wren_cnt = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // transaction-level model: one outstanding transfer,
  // described by its kind and the cycle count since accept
  logic [15:0] e_rdata, e_hex, e_mwdata;
  logic [9:0]  e_maddr;
  logic [9:0]  h1, h2;
  bit          m_act, m_io, m_wr, m_prd, m_pwr;
  bit          was_idle, rr, wr;
  int          m_k;

  function automatic int dur();
    return (!m_io && !m_wr) ? W + 1 : 2;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      e_rdata = '0; e_hex = '0; e_mwdata = '0;
      e_maddr = '0; h1 = '0; h2 = '0;
      m_act = 0; m_k = 0; m_io = 0; m_wr = 0;
      m_prd = 1; m_pwr = 1;
    end else begin
      was_idle = !m_act;
      if (m_act) begin
        if (m_io && m_k == 1) begin
          if (m_wr) e_hex = e_mwdata;
          else e_rdata = {6'b0, h2};
        end
        if (!m_io && !m_wr && m_k == W)
          e_rdata = MEM_RDATA;
        m_k++;
        if (m_k > dur()) m_act = 0;
      end
      h2 = h1;
      h1 = SW;
      rr = CPU_RD && !m_prd;
      wr = CPU_WR && !m_pwr;
      if (was_idle && (rr || wr)) begin
        m_wr = wr;
        m_io = (ADDR == IOA);
        e_maddr = ADDR[9:0];
        e_mwdata = CPU_WDATA;
        m_act = 1;
        m_k = 1;
      end
      m_prd = CPU_RD;
      m_pwr = CPU_WR;
    end
    #1;
    chk("cpu_rdata", CPU_RDATA, e_rdata);
    chk("hex_data", HEX_DATA, e_hex);
    chk("mem_addr", {6'b0, MEM_ADDR}, {6'b0, e_maddr});
    chk("mem_wdata", MEM_WDATA, e_mwdata);
    chk("busy", {15'b0, BUSY}, {15'b0, m_act});
    chk("r", {15'b0, R},
        {15'b0, m_act && m_k == dur()});
    chk("mem_rden", {15'b0, MEM_RDEN},
        {15'b0, m_act && !m_io && !m_wr && m_k <= W});
    chk("mem_wren", {15'b0, MEM_WREN},
        {15'b0, m_act && !m_io && m_wr && m_k == 1});
    chk("en_excl", {15'b0, MEM_RDEN && MEM_WREN}, 16'h0);
    if (R === 1'b1) r_cnt++;
    if (MEM_RDEN === 1'b1) rden_cnt++;
    if (MEM_WREN === 1'b1) wren_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  int r0, rd0, wr0;

  task automatic snap();
    r0 = r_cnt; rd0 = rden_cnt; wr0 = wren_cnt;
  endtask

  initial begin
    Reset = 1; ADDR = '0; CPU_WDATA = '0;
    CPU_RD = 0; CPU_WR = 0; SW = '0; MEM_RDATA = '0;
    cyc(3);
    Reset = 0;
    cyc(1);
    chk("rst_r", {15'b0, R}, 16'h0);
    chk("rst_busy", {15'b0, BUSY}, 16'h0);
    chk("rst_rdata", CPU_RDATA, 16'h0);
    chk("rst_hex", HEX_DATA, 16'h0);

    // switch read through the I/O address
    SW = 10'h2A5;
    cyc(3);
    snap();
    ADDR = 16'hFFFF; CPU_RD = 1;
    cyc(1);
    chk("io_rd_busy", {15'b0, BUSY}, 16'h1);
    chk("io_rd_r_early", {15'b0, R}, 16'h0);
    cyc(1);
    chk("io_rd_r", {15'b0, R}, 16'h1);
    chk("io_rd_data", CPU_RDATA, 16'h02A5);
    CPU_RD = 0;
    cyc(2);
    chk("io_rd_rden", 16'(rden_cnt - rd0), 16'h0);

    // hex display write
    snap();
    ADDR = 16'hFFFF; CPU_WDATA = 16'hBEEF; CPU_WR = 1;
    cyc(2);
    chk("io_wr_r", {15'b0, R}, 16'h1);
    chk("io_wr_hex", HEX_DATA, 16'hBEEF);
    CPU_WR = 0;
    cyc(2);
    chk("io_wr_wren", 16'(wren_cnt - wr0), 16'h0);
    chk("io_wr_rdata", CPU_RDATA, 16'h02A5);

    // aliased memory write then read back
    snap();
    ADDR = 16'h0403; CPU_WDATA = 16'h1234; CPU_WR = 1;
    cyc(1);
    chk("mw_addr", {6'b0, MEM_ADDR}, 16'h0003);
    chk("mw_wren", {15'b0, MEM_WREN}, 16'h1);
    CPU_WR = 0;
    cyc(1);
    chk("mw_r", {15'b0, R}, 16'h1);
    cyc(2);
    chk("mw_wren_cnt", 16'(wren_cnt - wr0), 16'h1);
    snap();
    ADDR = 16'h0003; MEM_RDATA = 16'h1234; CPU_RD = 1;
    cyc(2);
    chk("mr_r_early", {15'b0, R}, 16'h0);
    cyc(1);
    chk("mr_r", {15'b0, R}, 16'h1);
    chk("mr_data", CPU_RDATA, 16'h1234);
    CPU_RD = 0;
    cyc(2);
    chk("mr_rden_cnt", 16'(rden_cnt - rd0), 16'h2);

    // simultaneous strobes: write wins
    snap();
    ADDR = 16'h0010; CPU_RD = 1; CPU_WR = 1;
    cyc(5);
    CPU_RD = 0; CPU_WR = 0;
    cyc(2);
    chk("both_r", 16'(r_cnt - r0), 16'h1);
    chk("both_rden", 16'(rden_cnt - rd0), 16'h0);
    chk("both_wren", 16'(wren_cnt - wr0), 16'h1);

    // held read strobe fires once
    snap();
    ADDR = 16'h0005; CPU_RD = 1;
    cyc(20);
    chk("held_r", 16'(r_cnt - r0), 16'h1);
    CPU_RD = 0;
    cyc(1);
    CPU_RD = 1;
    cyc(6);
    CPU_RD = 0;
    cyc(1);
    chk("reraise_r", 16'(r_cnt - r0), 16'h2);

    // reset during the first read-wait cycle
    snap();
    ADDR = 16'h0005; CPU_RD = 1;
    cyc(1);
    chk("ab_rden", {15'b0, MEM_RDEN}, 16'h1);
    Reset = 1;
    cyc(1);
    Reset = 0;
    chk("ab_rden_off", {15'b0, MEM_RDEN}, 16'h0);
    chk("ab_busy_off", {15'b0, BUSY}, 16'h0);
    cyc(6);
    chk("ab_no_r", 16'(r_cnt - r0), 16'h0);
    chk("ab_held", {15'b0, BUSY}, 16'h0);
    CPU_RD = 0;
    cyc(1);
    CPU_RD = 1;
    cyc(5);
    CPU_RD = 0;
    chk("ab_reraise", 16'(r_cnt - r0), 16'h1);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) CPU_RD = ~CPU_RD;
      if ($urandom_range(0, 3) == 0) CPU_WR = ~CPU_WR;
      case ($urandom_range(0, 3))
        0: ADDR = IOA;
        1: ADDR = {6'($urandom), 10'($urandom_range(0, 7))};
        default: ADDR = 16'($urandom);
      endcase
      CPU_WDATA = 16'($urandom);
      MEM_RDATA = 16'($urandom);
      if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
      cyc(1);
    end
    Reset = 0; CPU_RD = 0; CPU_WR = 0;
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
